// File: rtl/rxx_row_serializer.sv
// Replays one MAT_DIM x MAT_DIM matrix beat as MAT_DIM row beats with tlast/tuser framing.
// Define RXX_ROW_SER_DOUBLE_BUFFER_EN to add a pending matrix register for gapless output.
module rxx_row_serializer #(
    parameter int unsigned NUM_SIZE = 32,
    parameter int unsigned MAT_DIM  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clken,
    input  logic [MAT_DIM*MAT_DIM*NUM_SIZE-1:0] s_axis_tdata,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    input  logic                                s_axis_tuser,
    output logic                                s_axis_tready,
    output logic [MAT_DIM*NUM_SIZE-1:0]         m_axis_tdata,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tuser,
    input  logic                                m_axis_tready
);

    localparam int unsigned RowW = MAT_DIM * NUM_SIZE;
    localparam int unsigned MatW = MAT_DIM * RowW;
    localparam int unsigned CntW = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e            state_q;
    logic [CntW-1:0]   row_q;
    logic [MatW-1:0]   act_data_q;
    logic              act_user_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              last_row;

    // Framing is regenerated per matrix, so the upstream tlast is not needed.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
    logic [MatW-1:0]   pend_data_q;
    logic              pend_user_q;
    logic              pend_full_q;

    assign s_axis_tready = clken & ~reset & ~pend_full_q;
`else
    assign s_axis_tready = clken & ~reset & (state_q == StIdle);
`endif

    assign m_axis_tvalid = clken & (state_q == StSend);
    assign in_xfer       = s_axis_tvalid & s_axis_tready;
    assign out_xfer      = m_axis_tvalid & m_axis_tready;
    assign last_row      = (row_q == CntW'(MAT_DIM - 1));
    assign m_axis_tlast  = (state_q == StSend) & last_row;
    assign m_axis_tuser  = (state_q == StSend) & act_user_q & (row_q == '0);

    always_comb begin
        m_axis_tdata = '0;
        for (int r = 0; r < MAT_DIM; r++) begin
            if (row_q == CntW'(r)) begin
                m_axis_tdata = act_data_q[r*RowW +: RowW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            act_data_q  <= '0;
            act_user_q  <= 1'b0;
`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
            pend_data_q <= '0;
            pend_user_q <= 1'b0;
            pend_full_q <= 1'b0;
`endif
        end else if (clken) begin
            unique case (state_q)
                StIdle: begin
                    if (in_xfer) begin
                        act_data_q <= s_axis_tdata;
                        act_user_q <= s_axis_tuser;
                        row_q      <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (out_xfer) begin
                        if (!last_row) begin
                            row_q <= row_q + CntW'(1);
                        end else begin
                            row_q <= '0;
`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
                            if (pend_full_q) begin
                                act_data_q  <= pend_data_q;
                                act_user_q  <= pend_user_q;
                                pend_full_q <= 1'b0;
                            end else if (in_xfer) begin
                                act_data_q <= s_axis_tdata;
                                act_user_q <= s_axis_tuser;
                            end else begin
                                state_q <= StIdle;
                            end
`else
                            state_q <= StIdle;
`endif
                        end
                    end
`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
                    // A matrix arriving mid-replay parks in the pending slot.
                    if (in_xfer && !(out_xfer && last_row)) begin
                        pend_data_q <= s_axis_tdata;
                        pend_user_q <= s_axis_tuser;
                        pend_full_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rxx_row_serializer.sv
// Randomized and directed bench for rxx_row_serializer against a queue-of-rows reference model.
module tb_rxx_row_serializer;

    localparam int unsigned NUM_SIZE = 32;
    localparam int unsigned MAT_DIM  = 4;
    localparam int unsigned RowW     = MAT_DIM * NUM_SIZE;
    localparam int unsigned MatW     = MAT_DIM * RowW;
`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
    localparam int unsigned Backlog  = MAT_DIM;
`else
    localparam int unsigned Backlog  = 0;
`endif

    typedef struct packed {
        logic [RowW-1:0] data;
        logic            last;
        logic            user;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            clken;
    logic [MatW-1:0] s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tuser;
    logic            s_tready;
    logic [RowW-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tuser;
    logic            m_tready;

    int total = 0;
    int bad   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    rxx_row_serializer #(
        .NUM_SIZE (NUM_SIZE),
        .MAT_DIM  (MAT_DIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready)
    );

    function automatic logic [RowW-1:0] row_of(input logic [MatW-1:0] m, input int r);
        return m[r*RowW +: RowW];
    endfunction

    // Element (r,c) = 0x00010000*r + c
    function automatic logic [MatW-1:0] spec_matrix();
        logic [MatW-1:0] m;
        for (int r = 0; r < MAT_DIM; r++)
            for (int c = 0; c < MAT_DIM; c++)
                m[(r*MAT_DIM+c)*NUM_SIZE +: NUM_SIZE] = NUM_SIZE'(32'h00010000 * r + c);
        return m;
    endfunction

    function automatic logic [MatW-1:0] rand_mat();
        logic [MatW-1:0] m;
        for (int i = 0; i < MatW; i += 32) m[i +: 32] = $urandom();
        return m;
    endfunction

    task automatic push_matrix(input logic [MatW-1:0] m, input logic u);
        beat_t b;
        for (int r = 0; r < MAT_DIM; r++) begin
            b.data = row_of(m, r);
            b.last = (r == MAT_DIM - 1);
            b.user = u && (r == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clken = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tdata = '0; m_tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({m_tvalid, m_tlast, m_tuser} !== 3'b000)
            begin bad++; $display("FAIL reset_ctrl got=%b want=000", {m_tvalid, m_tlast, m_tuser}); end
        total++;
        if (m_tdata !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", m_tdata); end
        total++;
        if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_sready got=%b want=0", s_tready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL release_sready got=%b want=1", s_tready); end
        total++;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL release_mvalid got=%b want=0", m_tvalid); end
    endtask

    task automatic test_single();
        logic [MatW-1:0] m = spec_matrix();
        logic [RowW-1:0] row0 = 128'h00000003_00000002_00000001_00000000;
        @(negedge clk);
        s_tdata = m; s_tuser = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1; clken = 1'b1;
        #1;
        total++;
        if ({s_tready, m_tvalid} !== 2'b10)
            begin bad++; $display("FAIL single_accept got=%b want=10", {s_tready, m_tvalid}); end
        @(negedge clk);
        s_tvalid = 1'b0; s_tuser = 1'b0;
        #1;
        total++;
        if (m_tdata !== row0) begin bad++; $display("FAIL single_row0 got=%h want=%h", m_tdata, row0); end
        for (int r = 0; r < MAT_DIM; r++) begin
            if (r > 0) begin @(negedge clk); #1; end
            total++;
            if ({m_tvalid, m_tlast, m_tuser} !== {1'b1, r == MAT_DIM - 1, r == 0})
                begin bad++; $display("FAIL single_ctrl r=%0d got=%b", r, {m_tvalid, m_tlast, m_tuser}); end
            total++;
            if (m_tdata !== row_of(m, r))
                begin bad++; $display("FAIL single_data r=%0d got=%h want=%h", r, m_tdata, row_of(m, r)); end
        end
        @(negedge clk);
        #1;
        total++;
        if ({m_tvalid, s_tready} !== 2'b01)
            begin bad++; $display("FAIL single_idle got=%b want=01", {m_tvalid, s_tready}); end
    endtask

    task automatic test_stall();
        logic [MatW-1:0] m = spec_matrix();
        int nb = 0;
        @(negedge clk);
        s_tdata = m; s_tuser = 1'b1; s_tvalid = 1'b1; m_tready = 1'b0;
        #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", s_tready); end
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            m_tready = (k % 4 == 0) || (k % 4 == 3);
            #1;
            if (m_tvalid === 1'b1) begin
                total++;
                if (nb >= MAT_DIM) begin
                    bad++; $display("FAIL stall_extra got=beat%0d want=none", nb);
                end else if ({m_tdata, m_tlast, m_tuser} !==
                             {row_of(m, nb), nb == MAT_DIM - 1, nb == 0}) begin
                    bad++;
                    $display("FAIL stall_row k=%0d got=%h/%b%b want=%h row%0d", k, m_tdata, m_tlast,
                             m_tuser, row_of(m, nb), nb);
                end
                if (m_tready) nb++;
            end
        end
        total++;
        if (nb != MAT_DIM) begin bad++; $display("FAIL stall_count got=%0d want=%0d", nb, MAT_DIM); end
    endtask

    task automatic test_back_to_back();
        logic [MatW-1:0] a = rand_mat();
        logic [MatW-1:0] b = rand_mat();
        logic [RowW-1:0] exp_row;
        bit er[12];
        bit ev[12];
        int phase = 0;
        int nb = 0;
`ifdef RXX_ROW_SER_DOUBLE_BUFFER_EN
        er = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        ev = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
`else
        er = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
        ev = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
`endif
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            s_tvalid = (phase < 2);
            s_tdata  = (phase == 0) ? a : b;
            s_tuser  = (phase == 0);
            m_tready = 1'b1;
            #1;
            total++;
            if (s_tready !== er[k]) begin bad++; $display("FAIL b2b_sready k=%0d got=%b want=%b", k, s_tready, er[k]); end
            total++;
            if (m_tvalid !== ev[k]) begin bad++; $display("FAIL b2b_mvalid k=%0d got=%b want=%b", k, m_tvalid, ev[k]); end
            if (m_tvalid === 1'b1 && nb < 2 * MAT_DIM) begin
                exp_row = row_of((nb < MAT_DIM) ? a : b, nb % MAT_DIM);
                total++;
                if ({m_tdata, m_tlast, m_tuser} !== {exp_row, nb % MAT_DIM == MAT_DIM - 1, nb == 0})
                    begin bad++; $display("FAIL b2b_beat n=%0d got=%h want=%h", nb, m_tdata, exp_row); end
                nb++;
            end
            if (s_tvalid && s_tready) phase++;
        end
        s_tvalid = 1'b0;
        total++;
        if (nb != 2 * MAT_DIM) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", nb, 2 * MAT_DIM); end
    endtask

    task automatic test_clken();
        logic [MatW-1:0] m = rand_mat();
        @(negedge clk);
        s_tdata = m; s_tuser = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; clken = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL clken_accept got=%b want=1", s_tready); end
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        total++;
        if (m_tdata !== row_of(m, 0)) begin bad++; $display("FAIL clken_row0 got=%h", m_tdata); end
        @(negedge clk);
        m_tready = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tdata} !== {1'b1, row_of(m, 1)})
            begin bad++; $display("FAIL clken_row1_pre got=%b/%h", m_tvalid, m_tdata); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clken = 1'b0; m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = rand_mat();
            #1;
            total++;
            if ({m_tvalid, s_tready} !== 2'b00)
                begin bad++; $display("FAIL clken_gated k=%0d got=%b want=00", k, {m_tvalid, s_tready}); end
        end
        for (int r = 1; r < MAT_DIM; r++) begin
            @(negedge clk);
            clken = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
            #1;
            total++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, r == MAT_DIM - 1, row_of(m, r)})
                begin bad++; $display("FAIL clken_resume r=%0d got=%b%b/%h want=%h", r, m_tvalid, m_tlast, m_tdata, row_of(m, r)); end
        end
        @(negedge clk);
        #1;
        total++;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL clken_end got=%b want=0", m_tvalid); end
    endtask

    task automatic test_reset_mid();
        logic [MatW-1:0] m  = rand_mat();
        logic [MatW-1:0] m2 = rand_mat();
        @(negedge clk);
        s_tdata = m; s_tuser = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (3) begin @(negedge clk); s_tvalid = 1'b0; end
        m_tready = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tdata} !== {1'b1, row_of(m, 2)})
            begin bad++; $display("FAIL rstmid_row2 got=%b/%h", m_tvalid, m_tdata); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({m_tvalid, m_tlast, m_tuser, s_tready} !== 4'b0000)
            begin bad++; $display("FAIL rstmid_ctrl got=%b want=0000", {m_tvalid, m_tlast, m_tuser, s_tready}); end
        total++;
        if (m_tdata !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", m_tdata); end
        @(negedge clk);
        reset = 1'b0; m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            total++;
            if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet k=%0d got=%b want=0", k, m_tvalid); end
        end
        @(negedge clk);
        s_tdata = m2; s_tuser = 1'b1; s_tvalid = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", s_tready); end
        @(negedge clk);
        s_tvalid = 1'b0; s_tuser = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tuser, m_tdata} !== {2'b11, row_of(m2, 0)})
            begin bad++; $display("FAIL rstmid_new_row0 got=%b%b/%h want=%h", m_tvalid, m_tuser, m_tdata, row_of(m2, 0)); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [MatW-1:0] offer;
        logic            offer_user;
        logic            have_offer = 1'b0;
        logic            exp_rdy;
        logic            exp_vld;
        int accepted = 0;
        int cyc = 0;
        exp_q.delete();
        while ((accepted < 1000 || exp_q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!have_offer && accepted < 1000) begin
                offer = rand_mat(); offer_user = 1'($urandom_range(0, 1)); have_offer = 1'b1;
            end
            clken    = ($urandom_range(0, 9) != 0);
            s_tvalid = have_offer && ($urandom_range(0, 9) < 7);
            s_tdata  = offer;
            s_tuser  = offer_user;
            s_tlast  = 1'($urandom_range(0, 1));
            m_tready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = clken && (exp_q.size() <= Backlog);
            exp_vld = clken && (exp_q.size() > 0);
            total++;
            if (s_tready !== exp_rdy) begin bad++; $display("FAIL rand_sready cyc=%0d got=%b want=%b", cyc, s_tready, exp_rdy); end
            total++;
            if (m_tvalid !== exp_vld) begin bad++; $display("FAIL rand_mvalid cyc=%0d got=%b want=%b", cyc, m_tvalid, exp_vld); end
            if (m_tvalid === 1'b1 && exp_q.size() > 0) begin
                total++;
                if ({m_tdata, m_tlast, m_tuser} !== exp_q[0])
                    begin bad++; $display("FAIL rand_beat cyc=%0d got=%h/%b%b want=%h/%b%b", cyc, m_tdata, m_tlast, m_tuser, exp_q[0].data, exp_q[0].last, exp_q[0].user); end
                if (m_tready) void'(exp_q.pop_front());
            end
            if (s_tvalid && s_tready) begin
                push_matrix(offer, offer_user);
                accepted++;
                have_offer = 1'b0;
            end
        end
        s_tvalid = 1'b0; clken = 1'b1;
        total++;
        if (accepted != 1000 || exp_q.size() != 0)
            begin bad++; $display("FAIL rand_budget got=%0d/%0d want=1000/0", accepted, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_clken();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rxx_row_serializer.md
# rxx_row_serializer

Downstream reader for the covariance estimator's matrix output. It accepts one full MAT_DIM x MAT_DIM complex matrix per AXI-Stream beat and replays it as MAT_DIM row beats, each MAT_DIM elements wide, with start and end framing. It feeds narrower consumers such as the eigen-solver front end and host DMA, which cannot take a whole matrix in a single beat.

## Interface
- NUM_SIZE, 32, bits per complex element, {imag[NUM_SIZE/2], real[NUM_SIZE/2]}; opaque to this block
- MAT_DIM, 4, matrix dimension, which is both the row count and the elements per row
- clk  input  1  single clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- clken  input  1  clock enable; low stalls the block
- s_axis_tdata  input  MAT_DIM*MAT_DIM*NUM_SIZE  matrix; element (r,c) at bits [(r*MAT_DIM+c)*NUM_SIZE +: NUM_SIZE]
- s_axis_tvalid  input  1  upstream matrix valid
- s_axis_tlast  input  1  accepted but ignored; framing is regenerated per matrix
- s_axis_tuser  input  1  matrix tag, captured with the matrix
- s_axis_tready  output  1  block can accept a matrix
- m_axis_tdata  output  MAT_DIM*NUM_SIZE  one row; element c at bits [c*NUM_SIZE +: NUM_SIZE]
- m_axis_tvalid  output  1  row valid
- m_axis_tlast  output  1  high on row MAT_DIM-1 of every matrix
- m_axis_tuser  output  1  captured s_axis_tuser on row 0; 0 on all other rows
- m_axis_tready  input  1  downstream ready

## Operation
- Storage: one active register holding the matrix and tuser, plus a row counter of width $clog2(MAT_DIM).
- Two states:
  - IDLE: active register empty.
  - SEND: active register full.
- Input transfer: occurs when s_axis_tvalid & s_axis_tready & clken. In IDLE it loads the active register, clears the row counter and moves to SEND.
- In SEND:
  - m_axis_tvalid=1.
  - m_axis_tdata = row[row counter] of the active register.
  - m_axis_tlast = (row counter == MAT_DIM-1).
  - m_axis_tuser = captured tuser & (row counter == 0).
- Output transfer: occurs when m_axis_tvalid & m_axis_tready & clken.
  - Before the last row, the row counter increments.
  - On the last row, the row counter returns to 0 and the state returns to IDLE, unless a pending matrix exists (see Configuration).
- Rows leave in order 0..MAT_DIM-1. Data is passed bit-exact with no arithmetic.
- m_axis_tdata, tlast and tuser are stable while m_axis_tvalid=1 and m_axis_tready=0.
- clken low:
  - No register updates.
  - s_axis_tready and m_axis_tvalid are forced to 0, so no transfer occurs.
  - State and row position resume unchanged when clken returns high.
- Reset asserted mid-matrix: the partial matrix is discarded; there is no output after reset until a new input transfer.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - s_axis_tready=0 while reset is asserted.
  - State IDLE, row counter 0.
- Deassert reset, with clken=1: s_axis_tready=1 in the first cycle after deassertion.
- Latency: an input transfer at edge N gives row 0 valid in the cycle after edge N. The minimum is 1 cycle, with no combinational path from s_axis to m_axis.
- No combinational path from m_axis_tready to s_axis_tready.
- Back-pressure holds the current row indefinitely. Row count per matrix is always exactly MAT_DIM.
- Throughput without the macro: s_axis_tready = clken & (state==IDLE), giving 1 matrix per MAT_DIM+1 cycles at full rate.

## Configuration
- Macro: RXX_ROW_SER_DOUBLE_BUFFER_EN.
- Defined:
  - Adds a pending register holding a matrix and its tuser.
  - s_axis_tready = clken & !pending_full, so the block accepts while in SEND.
  - On a last-row output transfer with pending_full, the pending matrix moves to the active register in the same edge, the row counter goes to 0 and the state stays in SEND. Rows are gapless, giving 1 matrix per MAT_DIM cycles.
  - Simultaneous last-row output and input transfer with pending empty: the input loads the active register directly.
  - Simultaneous last-row output and input transfer with pending full: cannot occur, because s_axis_tready is 0.
- Undefined: single register, with behaviour as in Timing.

## Test plan
- Reset, then one matrix with element (r,c)=32'h00010000*r + c and tuser=1, m_axis_tready=1 -> 4 beats. Beat 0 = {32'h3,32'h2,32'h1,32'h0}. tuser=1 on beat 0 only. tlast on beat 3 only. Row 0 appears 1 cycle after acceptance.
- Same matrix with m_axis_tready toggled 1,0,0,1,... -> each row is held stable while stalled. Exactly 4 beats, in order 0..3.
- Two back-to-back matrices A then B, tready=1:
  - Without the macro: s_axis_tready=0 for 4 cycles, with a 1-cycle bubble between A row 3 and B row 0.
  - With the macro: 8 consecutive valid beats, with no bubble.
- clken dropped for 3 cycles during row 1 -> m_axis_tvalid=0 and s_axis_tready=0 for those cycles. Output resumes at row 1, with no row skipped or repeated.
- reset pulsed during row 2 -> all outputs go to 0 immediately. After release, no beats appear until a new matrix, and the new matrix starts at row 0.
- Random stimulus: 1000 matrices with random tvalid/tready -> scoreboard shows bit-exact rows, one tlast per 4 beats and tuser only on row 0.
